// File: rtl/clock_mon_pkg.sv
// Shared types for the divided-clock monitor: tracking states and error counter width.
package clock_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } mon_state_e;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/edge_sampler.sv
// Samples a clk-synchronous signal as data and flags its rising/falling transitions.
// Detection is suppressed for the first cycle after reset so a high input cannot fake a rise.
module edge_sampler (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s;
    logic primed;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= 1'b0;
            primed <= 1'b0;
        end else begin
            s      <= d;
            primed <= 1'b1;
        end
    end

    assign rise = primed &  d & ~s;
    assign fall = primed & ~d &  s;

endmodule

// File: rtl/clock_edge_monitor.sv
// Root-domain monitor for a divided clock: registered edge strobes, rising-edge tick count,
// and a half-period checker that locks after LOCK_COUNT correct intervals and flags drift.
module clock_edge_monitor
    import clock_mon_pkg::*;
#(
    parameter int DIVISOR    = 2,
    parameter int CNT_W      = 32,
    parameter int LOCK_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_div,
    input  logic                 enable,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_W-1:0]     tick_count,
    output logic [CNT_W-1:0]     half_period,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int               GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_VAL = GOOD_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  DIV_VAL  = CNT_W'(DIVISOR);

    logic              sampledRise;
    logic              sampledFall;
    logic              anyEdge;
    logic [CNT_W-1:0]  runLen;
    logic [GOOD_W-1:0] goodCnt;
    logic [GOOD_W-1:0] nextGood;
    mon_state_e        state;
    mon_state_e        nextState;
    logic              periodOk;
    logic              mismatchEvt;
    logic              stallEvt;

    edge_sampler u_sampler (
        .clk  (clk),
        .rst  (rst),
        .d    (clk_div),
        .rise (sampledRise),
        .fall (sampledFall)
    );

    assign anyEdge  = sampledRise | sampledFall;
    assign periodOk = (runLen == DIV_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            goodCnt <= '0;
        end else begin
            state   <= nextState;
            goodCnt <= nextGood;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        nextState   = state;
        nextGood    = goodCnt;
        mismatchEvt = 1'b0;
        stallEvt    = 1'b0;
        if (!enable) begin
            nextState = IDLE;
            nextGood  = '0;
        end else if (state == IDLE) begin
            // The interval before the first edge is partial, so it is never judged.
            if (anyEdge)
                nextState = SYNC;
        end else if (anyEdge) begin
            if (periodOk) begin
                nextGood  = (goodCnt == LOCK_VAL) ? goodCnt : goodCnt + 1'b1;
                nextState = (nextGood == LOCK_VAL) ? LOCKED : TRACK;
            end else begin
                mismatchEvt = 1'b1;
                nextGood    = '0;
                nextState   = SYNC;
            end
        end else if (state != SYNC && periodOk) begin
            // Run has reached the expected length with no edge: the next edge is overdue.
            stallEvt  = 1'b1;
            nextGood  = '0;
            nextState = IDLE;
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            runLen      <= '0;
            tick_count  <= '0;
            half_period <= '0;
            error       <= 1'b0;
            err_count   <= '0;
        end else if (!enable) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            runLen     <= '0;
        end else begin
            rise_pulse <= sampledRise;
            fall_pulse <= sampledFall;
            if (anyEdge)
                runLen <= CNT_W'(1);
            else if (runLen != '1)
                runLen <= runLen + 1'b1;
            if (sampledRise)
                tick_count <= tick_count + 1'b1;
            if (anyEdge && state != IDLE)
                half_period <= runLen;
            if (mismatchEvt || stallEvt) begin
                error <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Directed bench: a DIVISOR=2 monitor through lock, disable, stall and reset scenarios,
// plus a DIVISOR=3 monitor fed the same divide-by-2 signal to exercise error saturation.
module tb_clock_edge_monitor;
    import clock_mon_pkg::*;

    logic clk;
    logic rst;
    logic clkDiv;
    logic enable;
    logic enable3;

    logic                 riseP, fallP, lockedO, errorO;
    logic [31:0]          tickCnt, halfPer;
    logic [ERR_CNT_W-1:0] errCnt;

    logic                 riseP3, fallP3, lockedO3, errorO3;
    logic [31:0]          tickCnt3, halfPer3;
    logic [ERR_CNT_W-1:0] errCnt3;

    int total = 0;
    int bad   = 0;

    clock_edge_monitor #(.DIVISOR(2), .CNT_W(32), .LOCK_COUNT(2)) dut (
        .clk(clk), .rst(rst), .clk_div(clkDiv), .enable(enable),
        .rise_pulse(riseP), .fall_pulse(fallP), .tick_count(tickCnt),
        .half_period(halfPer), .locked(lockedO), .error(errorO), .err_count(errCnt)
    );

    clock_edge_monitor #(.DIVISOR(3), .CNT_W(32), .LOCK_COUNT(2)) dut3 (
        .clk(clk), .rst(rst), .clk_div(clkDiv), .enable(enable3),
        .rise_pulse(riseP3), .fall_pulse(fallP3), .tick_count(tickCnt3),
        .half_period(halfPer3), .locked(lockedO3), .error(errorO3), .err_count(errCnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clkDiv = 1'b0; enable = 1'b0; enable3 = 1'b0;
        tick(); tick();
        check("rst_rise",   32'(riseP),   0);
        check("rst_fall",   32'(fallP),   0);
        check("rst_tick",   tickCnt,      0);
        check("rst_half",   halfPer,      0);
        check("rst_locked", 32'(lockedO), 0);
        check("rst_error",  32'(errorO),  0);
        check("rst_errcnt", 32'(errCnt),  0);

        // Lock-up from a divide-by-2 source: discard first edge, lock on the third.
        rst = 1'b0; enable = 1'b1;
        tick(); tick();
        check("prime_rise", 32'(riseP), 0);
        clkDiv = 1'b1; tick();
        check("e1_rise",   32'(riseP),   1);
        check("e1_tick",   tickCnt,      1);
        check("e1_half",   halfPer,      0);
        check("e1_locked", 32'(lockedO), 0);
        tick();
        check("e1_rise_w", 32'(riseP), 0);
        clkDiv = 1'b0; tick();
        check("e2_fall",   32'(fallP),   1);
        check("e2_half",   halfPer,      2);
        check("e2_locked", 32'(lockedO), 0);
        tick();
        check("e2_fall_w", 32'(fallP), 0);
        clkDiv = 1'b1; tick();
        check("e3_locked", 32'(lockedO), 1);
        check("e3_tick",   tickCnt,      2);
        tick();

        for (int i = 0; i < 8; i++) begin
            clkDiv = 1'b0; tick();
            check("run_fall",  32'(fallP), 1);
            check("run_frise", 32'(riseP), 0);
            tick();
            clkDiv = 1'b1; tick();
            check("run_rise",  32'(riseP), 1);
            check("run_rfall", 32'(fallP), 0);
            check("run_tick",  tickCnt,    32'(3 + i));
            tick();
            check("run_rise_w", 32'(riseP), 0);
        end
        check("ten_tick",   tickCnt,      10);
        check("ten_locked", 32'(lockedO), 1);
        check("ten_error",  32'(errorO),  0);

        // Disable for three cycles; the first disabled cycle coincides with a fall.
        clkDiv = 1'b0; enable = 1'b0; tick();
        check("dis_fall",   32'(fallP),   0);
        check("dis_locked", 32'(lockedO), 0);
        tick();
        clkDiv = 1'b1; tick();
        check("dis_rise",   32'(riseP), 0);
        check("dis_tick",   tickCnt,    10);
        enable = 1'b1; tick();
        check("ren_rise", 32'(riseP), 0);
        clkDiv = 1'b0; tick();
        check("ren_fall",   32'(fallP),   1);
        check("ren_locked", 32'(lockedO), 0);
        tick();
        clkDiv = 1'b1; tick();
        check("ren_tick",    tickCnt,      11);
        check("ren_locked2", 32'(lockedO), 0);
        tick();
        clkDiv = 1'b0; tick();
        check("ren_relock", 32'(lockedO), 1);
        check("ren_error",  32'(errorO),  0);
        tick();

        // Stall: hold high for five cycles after a rise.
        clkDiv = 1'b1; tick();
        check("st_tick",   tickCnt,      12);
        check("st_locked", 32'(lockedO), 1);
        tick();
        check("st_pre",    32'(lockedO), 1);
        check("st_pre_err", 32'(errorO), 0);
        tick();
        check("st_locked0", 32'(lockedO), 0);
        check("st_error",   32'(errorO),  1);
        check("st_errcnt",  32'(errCnt),  1);
        tick(); tick();
        check("st_errcnt_hold", 32'(errCnt), 1);
        clkDiv = 1'b0; tick();
        check("st_fall", 32'(fallP),   1);
        check("st_half", halfPer,      2);
        tick();
        clkDiv = 1'b1; tick();
        check("st_tick2",   tickCnt,      13);
        check("st_locked1", 32'(lockedO), 0);
        tick();
        clkDiv = 1'b0; tick();
        check("st_relock",  32'(lockedO), 1);
        check("st_errcnt2", 32'(errCnt),  1);
        check("st_error2",  32'(errorO),  1);
        tick();

        // Reset coinciding with a rise, released while clk_div stays high.
        clkDiv = 1'b1; rst = 1'b1; tick();
        check("rr_rise",   32'(riseP),   0);
        check("rr_tick",   tickCnt,      0);
        check("rr_error",  32'(errorO),  0);
        check("rr_errcnt", 32'(errCnt),  0);
        tick();
        rst = 1'b0; tick();
        check("rr_prime_rise", 32'(riseP), 0);
        tick();
        check("rr_rise2",  32'(riseP),   0);
        check("rr_fall2",  32'(fallP),   0);
        check("rr_tick2",  tickCnt,      0);
        check("rr_half2",  halfPer,      0);
        check("rr_locked", 32'(lockedO), 0);

        // DIVISOR=3 monitor on a divide-by-2 stream: every edge after the first mismatches.
        clkDiv = 1'b0; enable3 = 1'b1; tick();
        check("rr_fall",  32'(fallP),  1);
        check("d3_fall",  32'(fallP3), 1);
        check("d3_err0",  32'(errCnt3), 0);
        for (int k = 1; k <= 300; k++) begin
            tick();
            clkDiv = ~clkDiv; tick();
            if (k == 1 || k == 2 || k == 100 || k == 254 || k == 255 || k == 256 || k == 300)
                check("d3_errcnt", 32'(errCnt3), 32'((k < 255) ? k : 255));
            if (k == 1)
                check("d3_half", halfPer3, 2);
            if (k == 2)
                check("d2_locked", 32'(lockedO), 1);
            if (k == 150)
                check("d3_locked", 32'(lockedO3), 0);
        end
        check("d3_error",  32'(errorO3),  1);
        check("d3_tick",   tickCnt3,      150);
        check("d2_tick",   tickCnt,       150);
        check("d2_error",  32'(errorO),   0);
        check("d2_locked", 32'(lockedO),  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_edge_monitor.md
# clock_edge_monitor

Root-clock-domain consumer of a divided clock produced by the on-chip clock divider. Samples the divided clock as data, emits one-cycle rise/fall strobes for downstream logic that must run on `clk` with enables, counts derived ticks, and checks that every half-period equals the expected `DIVISOR`. Sits directly downstream of the divider, replacing `posedge clkDiv` processes with strobe-qualified `posedge clk` logic and flagging any drift in the divider.

## Interface
- `DIVISOR`, 2, expected half-period of `clk_div` in `clk` cycles (≥1)
- `CNT_W`, 32, width of `tick_count` and `half_period`
- `LOCK_COUNT`, 2, consecutive correct half-periods required to assert `locked` (≥1)

- `clk` in 1: root clock, only clock in the block
- `rst` in 1: synchronous, active-high reset
- `clk_div` in 1: divided clock, sampled as data, synchronous to `clk`
- `enable` in 1: monitor enable; low forces IDLE
- `rise_pulse` out 1: one-cycle strobe per detected `clk_div` rising edge
- `fall_pulse` out 1: one-cycle strobe per detected falling edge
- `tick_count` out CNT_W: rising edges counted since reset, wraps mod 2^CNT_W
- `half_period` out CNT_W: last measured half-period length
- `locked` out 1: high in LOCKED state
- `error` out 1: sticky, set on any mismatch or stall
- `err_count` out 8: mismatch/stall events, saturates at 255

## Operation
- Edge sampler: `s <= clk_div` each cycle; `primed` flag reset 0, set after first post-reset cycle. Edge = `primed && (clk_div != s)`; rise if `clk_div`=1, fall otherwise. First cycle after reset only loads `s`.
- Run length `run`: on edge `run <= 1`; else `run <= run+1`, saturating at all-ones. At an edge, measured half-period = current `run`.
- States: IDLE, SYNC, TRACK, LOCKED; `good` counter for consecutive correct half-periods.
  - IDLE: edge → SYNC (partial first interval discarded).
  - SYNC/TRACK/LOCKED, edge with `run == DIVISOR`: `good++`; `good` reaching LOCK_COUNT → LOCKED, else TRACK.
  - SYNC/TRACK/LOCKED, edge with `run != DIVISOR`: mismatch event; `good <= 0`; → SYNC.
  - TRACK/LOCKED, no edge and `run == DIVISOR` (edge overdue): stall event; `good <= 0`; → IDLE.
- Each mismatch/stall event: `error <= 1`; `err_count` increments, holds at 255.
- `half_period <= run` on every edge outside IDLE; unchanged otherwise.
- `tick_count` increments on each `rise_pulse`.
- `enable` low: pulses suppressed, no counting or checking, state → IDLE, `good`/`run` cleared; `tick_count`, `half_period`, `error`, `err_count` retained. Only `rst` clears them.

## Timing
- Reset values: all outputs 0, state IDLE, `s`=0, `primed`=0, `run`=0, `good`=0.
- All outputs registered. `clk_div` change sampled at edge N → `rise_pulse`/`fall_pulse` high during cycle N→N+1, exactly one cycle; `tick_count`/`half_period`/state update at same edge N.
- `locked` asserts at the edge completing the LOCK_COUNT-th correct half-period; deasserts at the edge detecting mismatch/stall.
- Edge and `enable` falling in same cycle: enable wins, no pulse, no count.
- Edge and `rst` in same cycle: reset wins.
- Reset mid-operation with `clk_div` high: no spurious rise (priming cycle).

## Structure
- Shared package `clock_mon_pkg`: state enum `mon_state_e` {IDLE, SYNC, TRACK, LOCKED}, `ERR_CNT_W = 8`.
- Sub-module `edge_sampler` (clk, rst, d → rise, fall): holds `s` and `primed`; FSM, counters and checker in top.

## Test plan
- Drive from divider with DIVISOR=2: rise_pulse every 4 cycles, half_period=2, locked after 1 discarded + 2 correct edges (3rd edge after enable), error=0.
- Run 10 rising edges after reset → tick_count=10, rise/fall pulses alternate, each one cycle wide.
- Locked, hold clk_div high 5 cycles → stall at run==2: error=1, err_count=1, locked=0, IDLE; relocks 3 edges after toggling resumes.
- Monitor DIVISOR=3 fed by divide-by-2 source → never locks; err_count increments at each edge after the first, saturates at 255.
- Locked, drop enable 3 cycles → locked=0, no pulses, tick_count frozen; re-enable → relock after 3 edges, error still 0.
- Assert rst while clk_div=1, release → no rise_pulse on first cycle; all outputs 0 until next real edge.
